// File: rtl/hamming_accum_if.sv
// rtl/hamming_accum_if.sv - operand-pair input and window-result output bundle for hamming_accum
interface hamming_accum_if #(
   parameter int WIDTH = 8,
   parameter int SUM_W = 16
);
   localparam int DIST_W = $clog2(WIDTH + 1);

   logic              in_valid;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              out_valid;
   logic [SUM_W-1:0]  out_sum;
   logic [DIST_W-1:0] out_max;
   logic [15:0]       out_win;

   modport master (
      output in_valid, a, b,
      input  out_valid, out_sum, out_max, out_win
   );

   modport slave (
      input  in_valid, a, b,
      output out_valid, out_sum, out_max, out_win
   );
endinterface

// File: rtl/hamming_accum.sv
// rtl/hamming_accum.sv - windowed Hamming-distance accumulator; HAMMING_ACCUM_MAX_EN adds window-max tracking
module hamming_accum #(
   parameter int WIDTH  = 8,
   parameter int WINDOW = 8,
   parameter int SUM_W  = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   hamming_accum_if.slave bus
);
   localparam int DIST_W = $clog2(WIDTH + 1);
   localparam int CNT_W  = $clog2(WINDOW + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);
   localparam logic [SUM_W-1:0] SAT  = {SUM_W{1'b1}};

   typedef enum logic {IDLE, ACC} state_t;

   // stage 1: reduce
   logic              v1_q, v1_d;
   logic [DIST_W-1:0] d1_q, d1_d;
   logic [WIDTH-1:0]  diff;
   logic [DIST_W-1:0] pop;

   // stage 2: accumulate
   state_t            state_q, state_d;
   logic [SUM_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic [SUM_W-1:0]  done_sum_q, done_sum_d;
   logic [SUM_W-1:0]  acc_base;
   logic [SUM_W:0]    sum_ext;
   logic [SUM_W-1:0]  sum_sat;

   // stage 3: registered outputs
   logic              out_valid_q, out_valid_d;
   logic [SUM_W-1:0]  out_sum_q, out_sum_d;
   logic [15:0]       out_win_q, out_win_d;

`ifdef HAMMING_ACCUM_MAX_EN
   logic [DIST_W-1:0] mx_q, mx_d;
   logic [DIST_W-1:0] done_max_q, done_max_d;
   logic [DIST_W-1:0] out_max_q, out_max_d;
   logic [DIST_W-1:0] mx_base;
   logic [DIST_W-1:0] mx_new;
`endif

   // popcount of a^b by walking the bits; d1 holds its last value between pairs
   always_comb begin
      v1_d = bus.in_valid;
      d1_d = d1_q;
      diff = bus.a ^ bus.b;
      pop  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + DIST_W'(diff[i]);
      end
      if (bus.in_valid) begin
         d1_d = pop;
      end
   end

   // window FSM: accumulate with saturation, emit the completed window and restart from IDLE
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      done_sum_d = done_sum_q;
      acc_base   = (state_q == IDLE) ? '0 : acc_q;
      sum_ext    = {1'b0, acc_base} + (SUM_W + 1)'(d1_q);
      sum_sat    = sum_ext[SUM_W] ? SAT : sum_ext[SUM_W-1:0];
`ifdef HAMMING_ACCUM_MAX_EN
      mx_d       = mx_q;
      done_max_d = done_max_q;
      mx_base    = (state_q == IDLE) ? '0 : mx_q;
      mx_new     = (d1_q > mx_base) ? d1_q : mx_base;
`endif
      if (v1_q) begin
         if (cnt_q == LAST) begin
            done_d     = 1'b1;
            done_sum_d = sum_sat;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = IDLE;
`ifdef HAMMING_ACCUM_MAX_EN
            done_max_d = mx_new;
            mx_d       = '0;
`endif
         end else begin
            acc_d   = sum_sat;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ACC;
`ifdef HAMMING_ACCUM_MAX_EN
            mx_d    = mx_new;
`endif
         end
      end
   end

   // output stage: one-cycle pulse, results held until the next window
   always_comb begin
      out_valid_d = done_q;
      out_sum_d   = out_sum_q;
      out_win_d   = out_win_q;
`ifdef HAMMING_ACCUM_MAX_EN
      out_max_d   = out_max_q;
`endif
      if (done_q) begin
         out_sum_d = done_sum_q;
         out_win_d = out_win_q + 16'd1;
`ifdef HAMMING_ACCUM_MAX_EN
         out_max_d = done_max_q;
`endif
      end
   end

   // state registers; reset discards any partial window and in-flight sample
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         d1_q        <= '0;
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         done_sum_q  <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_win_q   <= '0;
`ifdef HAMMING_ACCUM_MAX_EN
         mx_q        <= '0;
         done_max_q  <= '0;
         out_max_q   <= '0;
`endif
      end else begin
         v1_q        <= v1_d;
         d1_q        <= d1_d;
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         done_sum_q  <= done_sum_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_win_q   <= out_win_d;
`ifdef HAMMING_ACCUM_MAX_EN
         mx_q        <= mx_d;
         done_max_q  <= done_max_d;
         out_max_q   <= out_max_d;
`endif
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_win   = out_win_q;
`ifdef HAMMING_ACCUM_MAX_EN
   assign bus.out_max   = out_max_q;
`else
   assign bus.out_max   = '0;
`endif
endmodule

// File: tb/tb_hamming_accum.sv
// tb/tb_hamming_accum.sv - three hamming_accum configurations checked against a window reference model
module tb_hamming_accum;
   logic clk;
   logic rst_n;

   hamming_accum_if #(.WIDTH(8), .SUM_W(16)) bus0 ();
   hamming_accum_if #(.WIDTH(8), .SUM_W(5))  bus1 ();
   hamming_accum_if #(.WIDTH(8), .SUM_W(16)) bus2 ();

   hamming_accum #(.WIDTH(8), .WINDOW(4), .SUM_W(16)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   hamming_accum #(.WIDTH(8), .WINDOW(4), .SUM_W(5))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   hamming_accum #(.WIDTH(8), .WINDOW(1), .SUM_W(16)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   int win_len [3] = '{4, 4, 1};
   int sum_cap [3] = '{65535, 31, 65535};

   // reference state: distances seen in the open window, and results in flight
   int w_dists [3][$];
   int pipe_v  [3][2];
   int pipe_s  [3][2];
   int pipe_m  [3][2];
   int exp_v   [3];
   int exp_s   [3];
   int exp_m   [3];
   int exp_w   [3];
   int obs_v   [3];
   int obs_s   [3];
   int obs_m   [3];
   int obs_w   [3];

   task automatic chk(input string tag, input int observed, input int expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic model_edge(input bit v, input logic [7:0] av, input logic [7:0] bv, input bit rn);
      int d, s, m;
      for (int k = 0; k < 3; k++) begin
         if (!rn) begin
            w_dists[k].delete();
            for (int j = 0; j < 2; j++) begin
               pipe_v[k][j] = 0; pipe_s[k][j] = 0; pipe_m[k][j] = 0;
            end
            exp_v[k] = 0; exp_s[k] = 0; exp_m[k] = 0; exp_w[k] = 0;
         end else begin
            exp_v[k] = pipe_v[k][1];
            if (pipe_v[k][1] != 0) begin
               exp_s[k] = pipe_s[k][1];
`ifdef HAMMING_ACCUM_MAX_EN
               exp_m[k] = pipe_m[k][1];
`endif
               exp_w[k] = (exp_w[k] + 1) % 65536;
            end
            pipe_v[k][1] = pipe_v[k][0];
            pipe_s[k][1] = pipe_s[k][0];
            pipe_m[k][1] = pipe_m[k][0];
            pipe_v[k][0] = 0;
            if (v) begin
               d = $countones(av ^ bv);
               w_dists[k].push_back(d);
               if (w_dists[k].size() == win_len[k]) begin
                  s = 0; m = 0;
                  foreach (w_dists[k][j]) begin
                     s += w_dists[k][j];
                     if (w_dists[k][j] > m) m = w_dists[k][j];
                  end
                  pipe_v[k][0] = 1;
                  pipe_s[k][0] = (s > sum_cap[k]) ? sum_cap[k] : s;
                  pipe_m[k][0] = m;
                  w_dists[k].delete();
               end
            end
         end
      end
   endtask

   task automatic step(input bit v, input logic [7:0] av, input logic [7:0] bv, input bit rn);
      rst_n = rn;
      bus0.in_valid = v; bus0.a = av; bus0.b = bv;
      bus1.in_valid = v; bus1.a = av; bus1.b = bv;
      bus2.in_valid = v; bus2.a = av; bus2.b = bv;
      @(posedge clk);
      model_edge(v, av, bv, rn);
      #1;
      obs_v[0] = int'(bus0.out_valid); obs_s[0] = int'(bus0.out_sum);
      obs_m[0] = int'(bus0.out_max);   obs_w[0] = int'(bus0.out_win);
      obs_v[1] = int'(bus1.out_valid); obs_s[1] = int'(bus1.out_sum);
      obs_m[1] = int'(bus1.out_max);   obs_w[1] = int'(bus1.out_win);
      obs_v[2] = int'(bus2.out_valid); obs_s[2] = int'(bus2.out_sum);
      obs_m[2] = int'(bus2.out_max);   obs_w[2] = int'(bus2.out_win);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("dut%0d out_valid @%0t", k, $time), obs_v[k], exp_v[k]);
         chk($sformatf("dut%0d out_sum @%0t", k, $time), obs_s[k], exp_s[k]);
         chk($sformatf("dut%0d out_max @%0t", k, $time), obs_m[k], exp_m[k]);
         chk($sformatf("dut%0d out_win @%0t", k, $time), obs_w[k], exp_w[k]);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b1);
   endtask

   int max8;
   logic [7:0] ra, rb;

   initial begin
`ifdef HAMMING_ACCUM_MAX_EN
      max8 = 8;
`else
      max8 = 0;
`endif
      rst_n = 1'b0;
      step(1'b0, 8'h00, 8'h00, 1'b0);
      step(1'b1, 8'hFF, 8'h00, 1'b0);
      chk("reset out_valid", obs_v[0], 0);
      chk("reset out_sum", obs_s[0], 0);
      chk("reset out_win", obs_w[0], 0);
      idle(1);

      // basic window
      step(1'b1, 8'hFF, 8'h00, 1'b1);
      step(1'b1, 8'h0F, 8'h00, 1'b1);
      step(1'b1, 8'h01, 8'h00, 1'b1);
      step(1'b1, 8'h00, 8'h00, 1'b1);
      idle(1);
      chk("basic early pulse", obs_v[0], 0);
      idle(1);
      chk("basic out_valid", obs_v[0], 1);
      chk("basic out_sum", obs_s[0], 13);
      chk("basic out_max", obs_m[0], max8);
      chk("basic out_win", obs_w[0], 1);
      idle(2);
      chk("basic hold out_sum", obs_s[0], 13);

      // gaps between pairs
      step(1'b1, 8'hFF, 8'h00, 1'b1); idle(3);
      step(1'b1, 8'h0F, 8'h00, 1'b1); idle(3);
      step(1'b1, 8'h01, 8'h00, 1'b1); idle(3);
      step(1'b1, 8'h00, 8'h00, 1'b1); idle(2);
      chk("gaps out_valid", obs_v[0], 1);
      chk("gaps out_sum", obs_s[0], 13);
      chk("gaps out_win", obs_w[0], 2);
      idle(1);

      // back-to-back windows, also saturating in the SUM_W=5 instance
      for (int i = 0; i < 8; i++) step(1'b1, 8'hAA, 8'h55, 1'b1);
      idle(2);
      chk("b2b out_valid", obs_v[0], 1);
      chk("b2b out_sum", obs_s[0], 32);
      chk("b2b out_max", obs_m[0], max8);
      chk("b2b out_win", obs_w[0], 4);
      chk("sat out_sum", obs_s[1], 31);
      idle(1);

      // mid-window reset, pair presented during reset is ignored
      step(1'b1, 8'hFF, 8'h00, 1'b1);
      step(1'b1, 8'hFF, 8'h00, 1'b1);
      step(1'b1, 8'hFF, 8'h00, 1'b0);
      chk("rst out_win", obs_w[0], 0);
      chk("rst out_sum", obs_s[0], 0);
      for (int i = 0; i < 4; i++) step(1'b1, 8'h03, 8'h00, 1'b1);
      idle(2);
      chk("rst2 out_valid", obs_v[0], 1);
      chk("rst2 out_sum", obs_s[0], 8);
      chk("rst2 out_win", obs_w[0], 1);

      // randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         step(($urandom_range(0, 3) != 0), ra, rb, ($urandom_range(0, 63) != 0));
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
